// File: rtl/rxiqdemod.sv
// rxiqdemod: 4-channel I/Q correlator against a 15 kHz reference at 100 kS/s.
// A single serial MAC computes the 8 products of each sample over 8 cycles.
// Results leave through a dvalid/dack handshake with a sticky overrun flag.
// Optional build macro IQDEMOD_CONTINUOUS_EN: windows re-arm back-to-back
// while enin stays high. Without it a rising edge of enin arms one window.
module rxiqdemod #(
    parameter int NWIN   = 200,
    parameter int DATA_W = 12,
    parameter int COEF_W = 12
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     endata,
    input  logic                     enin,
    input  logic signed [DATA_W-1:0] rx1,
    input  logic signed [DATA_W-1:0] rx2,
    input  logic signed [DATA_W-1:0] rx3,
    input  logic signed [DATA_W-1:0] rx4,
    output logic signed [31:0]       i1,
    output logic signed [31:0]       i2,
    output logic signed [31:0]       i3,
    output logic signed [31:0]       i4,
    output logic signed [31:0]       q1,
    output logic signed [31:0]       q2,
    output logic signed [31:0]       q3,
    output logic signed [31:0]       q4,
    output logic                     dvalid,
    input  logic                     dack,
    output logic                     overrun
);
    localparam int            NW     = (NWIN > 1) ? $clog2(NWIN) : 1;
    localparam int            PROD_W = DATA_W + COEF_W;
    localparam logic [NW-1:0] NLAST  = NW'(NWIN - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_MAC, S_DONE} state_t;

    state_t                   state;
    logic [NW-1:0]            n;
    logic [4:0]               k;
    logic [2:0]               step;
    logic signed [DATA_W-1:0] x_p0  [4];
    logic signed [31:0]       acc_i [4];
    logic signed [31:0]       acc_q [4];
    logic signed [31:0]       res_i [4];
    logic signed [31:0]       res_q [4];
    logic signed [COEF_W-1:0] coef;
    logic signed [31:0]       prod;
    logic                     arm;
    logic                     rearm;

    // round(2047*cos(2*pi*3k/20))
    function automatic logic signed [COEF_W-1:0] cos_rom(input logic [4:0] idx);
        int v;
        case (idx)
            5'd0:  v = 2047;   5'd1:  v = 1203;   5'd2:  v = -633;   5'd3:  v = -1947;
            5'd4:  v = -1656;  5'd5:  v = 0;      5'd6:  v = 1656;   5'd7:  v = 1947;
            5'd8:  v = 633;    5'd9:  v = -1203;  5'd10: v = -2047;  5'd11: v = -1203;
            5'd12: v = 633;    5'd13: v = 1947;   5'd14: v = 1656;   5'd15: v = 0;
            5'd16: v = -1656;  5'd17: v = -1947;  5'd18: v = -633;   5'd19: v = 1203;
            default: v = 0;
        endcase
        return COEF_W'(v);
    endfunction

    // round(2047*sin(2*pi*3k/20))
    function automatic logic signed [COEF_W-1:0] sin_rom(input logic [4:0] idx);
        int v;
        case (idx)
            5'd0:  v = 0;      5'd1:  v = 1656;   5'd2:  v = 1947;   5'd3:  v = 633;
            5'd4:  v = -1203;  5'd5:  v = -2047;  5'd6:  v = -1203;  5'd7:  v = 633;
            5'd8:  v = 1947;   5'd9:  v = 1656;   5'd10: v = 0;      5'd11: v = -1656;
            5'd12: v = -1947;  5'd13: v = -633;   5'd14: v = 1203;   5'd15: v = 2047;
            5'd16: v = 1203;   5'd17: v = -633;   5'd18: v = -1947;  5'd19: v = -1656;
            default: v = 0;
        endcase
        return COEF_W'(v);
    endfunction

    // Full-precision signed product, sign-extended to accumulator width
    function automatic logic signed [31:0] mac_product(input logic signed [DATA_W-1:0] x,
                                                       input logic signed [COEF_W-1:0] c);
        logic signed [PROD_W-1:0] xe;
        logic signed [PROD_W-1:0] ce;
        logic signed [PROD_W-1:0] p;
        xe = {{COEF_W{x[DATA_W-1]}}, x};
        ce = {{DATA_W{c[COEF_W-1]}}, c};
        p  = xe * ce;
        return {{(32-PROD_W){p[PROD_W-1]}}, p};
    endfunction

`ifdef IQDEMOD_CONTINUOUS_EN
    assign arm   = enin;
    assign rearm = enin;
`else
    logic enin_q;

    // Registered copy of enin so a window arms only on its rising edge
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) enin_q <= 1'b0;
        else        enin_q <= enin;
    end

    assign arm   = enin & ~enin_q;
    assign rearm = 1'b0;
`endif

    // Step order I1,Q1,I2,Q2,...: step[2:1] picks the channel, step[0] picks sin
    always_comb begin
        coef = step[0] ? sin_rom(k) : cos_rom(k);
        prod = mac_product(x_p0[step[2:1]], coef);
    end

    // Window sequencer, accumulators and result handshake
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            n       <= '0;
            k       <= '0;
            step    <= '0;
            dvalid  <= 1'b0;
            overrun <= 1'b0;
            for (int c = 0; c < 4; c++) begin
                x_p0[c]  <= '0;
                acc_i[c] <= '0;
                acc_q[c] <= '0;
                res_i[c] <= '0;
                res_q[c] <= '0;
            end
        end else begin
            if (dack && dvalid) dvalid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (arm) state <= S_WAIT;
                end
                // p0: sample capture
                S_WAIT: begin
                    if (!enin) begin
                        state <= S_IDLE;
                        n     <= '0;
                        k     <= '0;
                        for (int c = 0; c < 4; c++) begin
                            acc_i[c] <= '0;
                            acc_q[c] <= '0;
                        end
                    end else if (endata) begin
                        x_p0[0] <= rx1;
                        x_p0[1] <= rx2;
                        x_p0[2] <= rx3;
                        x_p0[3] <= rx4;
                        step    <= '0;
                        state   <= S_MAC;
                    end
                end
                // p1: serial multiply-accumulate
                S_MAC: begin
                    if (!enin) begin
                        state <= S_IDLE;
                        n     <= '0;
                        k     <= '0;
                        step  <= '0;
                        for (int c = 0; c < 4; c++) begin
                            acc_i[c] <= '0;
                            acc_q[c] <= '0;
                        end
                    end else begin
                        if (step[0]) acc_q[step[2:1]] <= acc_q[step[2:1]] + prod;
                        else         acc_i[step[2:1]] <= acc_i[step[2:1]] + prod;
                        if (step == 3'd7) begin
                            step <= '0;
                            if (n < NLAST) begin
                                n     <= n + NW'(1);
                                k     <= (k == 5'd19) ? 5'd0 : k + 5'd1;
                                state <= S_WAIT;
                            end else begin
                                state <= S_DONE;
                            end
                        end else begin
                            step <= step + 3'd1;
                        end
                    end
                end
                // p2: result publish
                S_DONE: begin
                    for (int c = 0; c < 4; c++) begin
                        res_i[c] <= acc_i[c];
                        res_q[c] <= acc_q[c];
                        acc_i[c] <= '0;
                        acc_q[c] <= '0;
                    end
                    dvalid <= 1'b1;
                    if (dvalid && !dack) overrun <= 1'b1;
                    n     <= '0;
                    k     <= '0;
                    state <= rearm ? S_WAIT : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign i1 = res_i[0];
    assign i2 = res_i[1];
    assign i3 = res_i[2];
    assign i4 = res_i[3];
    assign q1 = res_q[0];
    assign q2 = res_q[1];
    assign q3 = res_q[2];
    assign q4 = res_q[3];

endmodule

// File: tb/tb_rxiqdemod.sv
// Bench for rxiqdemod (NWIN=20). Expected sums come from a reference model
// that builds the tone table with $cos/$sin and sums sample*coefficient.
`timescale 1ns/1ps
module tb_rxiqdemod;
    localparam int NWIN = 20;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic endata = 1'b0;
    logic enin = 1'b0;
    logic dack = 1'b0;
    logic signed [11:0] rx1 = '0, rx2 = '0, rx3 = '0, rx4 = '0;
    logic signed [31:0] i1, i2, i3, i4, q1, q2, q3, q4;
    logic dvalid, overrun;

    logic signed [31:0] oi [4];
    logic signed [31:0] oq [4];

    int checks = 0;
    int errors = 0;
    int rc [20];
    int rs [20];
    int ei [4];
    int eq [4];
    int dv_cnt = 0;
    bit cnt_en = 1'b0;

    rxiqdemod #(.NWIN(NWIN)) dut (
        .clock(clock), .reset(reset), .endata(endata), .enin(enin),
        .rx1(rx1), .rx2(rx2), .rx3(rx3), .rx4(rx4),
        .i1(i1), .i2(i2), .i3(i3), .i4(i4),
        .q1(q1), .q2(q2), .q3(q3), .q4(q4),
        .dvalid(dvalid), .dack(dack), .overrun(overrun)
    );

    assign oi[0] = i1; assign oi[1] = i2; assign oi[2] = i3; assign oi[3] = i4;
    assign oq[0] = q1; assign oq[1] = q2; assign oq[2] = q3; assign oq[3] = q4;

    always #5 clock = ~clock;

    always @(negedge clock) if (cnt_en && dvalid) dv_cnt++;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("%s_i%0d", tag, c + 1), oi[c], ei[c]);
            check($sformatf("%s_q%0d", tag, c + 1), oq[c], eq[c]);
        end
    endtask

    task automatic send_sample(input int a, input int b, input int c, input int d);
        @(negedge clock);
        rx1 = 12'(a); rx2 = 12'(b); rx3 = 12'(c); rx4 = 12'(d);
        endata = 1'b1;
        @(negedge clock);
        endata = 1'b0;
        repeat (8) @(negedge clock);
    endtask

    // mode 0 random, 1 impulse, 2 DC, 3 tone; returns 8.5 cycles after last strobe
    task automatic run_window(input int mode, input int nsamp);
        int v [4];
        for (int c = 0; c < 4; c++) begin ei[c] = 0; eq[c] = 0; end
        for (int n = 0; n < nsamp; n++) begin
            for (int c = 0; c < 4; c++) begin
                case (mode)
                    1:       v[c] = (c == 0 && n == 0) ? 1000 : 0;
                    2:       v[c] = 100;
                    3:       v[c] = rc[n % 20] >>> 4;
                    default: v[c] = int'($urandom_range(0, 4095)) - 2048;
                endcase
                ei[c] += v[c] * rc[n % 20];
                eq[c] += v[c] * rs[n % 20];
            end
            send_sample(v[0], v[1], v[2], v[3]);
        end
    endtask

    task automatic arm_window();
        @(negedge clock); enin = 1'b0;
        @(negedge clock); enin = 1'b1;
    endtask

    task automatic ack_result();
        @(negedge clock); dack = 1'b1;
        @(negedge clock); dack = 1'b0;
    endtask

    initial begin
        int base;
        for (int kk = 0; kk < 20; kk++) begin
            rc[kk] = $rtoi($floor(2047.0 * $cos(2.0 * 3.14159265358979 * 3.0 * kk / 20.0) + 0.5));
            rs[kk] = $rtoi($floor(2047.0 * $sin(2.0 * 3.14159265358979 * 3.0 * kk / 20.0) + 0.5));
        end

        // reset state
        repeat (3) @(negedge clock);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("rst_i%0d", c + 1), oi[c], 0);
            check($sformatf("rst_q%0d", c + 1), oq[c], 0);
        end
        check("rst_dvalid", 32'(dvalid), 0);
        check("rst_overrun", 32'(overrun), 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // impulse with latency check
        arm_window();
        run_window(1, NWIN);
        check("imp_dvalid_early", 32'(dvalid), 0);
        @(negedge clock);
        check("imp_dvalid", 32'(dvalid), 1);
        check("imp_i1_abs", i1, 2047000);
        check_model("imp");
        ack_result();
        check("imp_ack_dvalid", 32'(dvalid), 0);
        check("imp_overrun", 32'(overrun), 0);

        // DC rejection
        arm_window();
        run_window(2, NWIN);
        @(negedge clock);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("dc_i%0d", c + 1), oi[c], 0);
            check($sformatf("dc_q%0d", c + 1), oq[c], 0);
        end
        ack_result();

        // tone
        arm_window();
        run_window(3, NWIN);
        @(negedge clock);
        check_model("tone");
        check("tone_pos", 32'(i1 > 0), 1);
        ack_result();

        // random window left pending, then DONE coincident with dack
        arm_window();
        run_window(0, NWIN);
        @(negedge clock);
        check_model("rnd1");
        arm_window();
        run_window(0, NWIN);
        dack = 1'b1;
        @(negedge clock);
        dack = 1'b0;
        check("coinc_dvalid", 32'(dvalid), 1);
        check("coinc_overrun", 32'(overrun), 0);
        check_model("coinc");
        ack_result();
        check("coinc_ack", 32'(dvalid), 0);

        // overrun: two results without acknowledge
        arm_window();
        run_window(0, NWIN);
        @(negedge clock);
        arm_window();
        run_window(0, NWIN);
        @(negedge clock);
        check("ovr_flag", 32'(overrun), 1);
        check("ovr_dvalid", 32'(dvalid), 1);
        check_model("ovr_w2");
        ack_result();
        check("ovr_ack_dvalid", 32'(dvalid), 0);
        check("ovr_sticky", 32'(overrun), 1);

        // abort at n=7, then a fresh window
        arm_window();
        run_window(0, 7);
        enin = 1'b0;
        repeat (30) @(negedge clock);
        check("abort_no_dvalid", 32'(dvalid), 0);
        arm_window();
        run_window(0, NWIN);
        @(negedge clock);
        check_model("post_abort");
        ack_result();

        // enin held high for three windows, dack held high
        base = dv_cnt;
        dack = 1'b1;
        cnt_en = 1'b1;
        arm_window();
        for (int w = 0; w < 3; w++) run_window(0, NWIN);
        repeat (12) @(negedge clock);
        cnt_en = 1'b0;
        dack = 1'b0;
`ifdef IQDEMOD_CONTINUOUS_EN
        check("hold_results", dv_cnt - base, 3);
`else
        check("hold_results", dv_cnt - base, 1);
`endif
        check("hold_dvalid_low", 32'(dvalid), 0);

        // re-toggle enin gives a second result
        arm_window();
        run_window(0, NWIN);
        @(negedge clock);
        check("retoggle_dvalid", 32'(dvalid), 1);
        check_model("retoggle");
        ack_result();

        // reset asserted during MAC
        arm_window();
        @(negedge clock);
        rx1 = 12'sd500; rx2 = -12'sd500; rx3 = 12'sd7; rx4 = 12'sd9;
        endata = 1'b1;
        @(negedge clock);
        endata = 1'b0;
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("mrst_i%0d", c + 1), oi[c], 0);
            check($sformatf("mrst_q%0d", c + 1), oq[c], 0);
        end
        check("mrst_dvalid", 32'(dvalid), 0);
        check("mrst_overrun", 32'(overrun), 0);
        enin = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        repeat (40) @(negedge clock);
        check("mrst_no_partial", 32'(dvalid), 0);
        arm_window();
        run_window(0, NWIN);
        @(negedge clock);
        check_model("post_rst");
        check("post_rst_overrun", 32'(overrun), 0);
        ack_result();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
